// File: rtl/mod_down_counter.sv
// Programmable modulo down-counter/timer with prescaler, one-shot or periodic reload,
// and a small run/pause/done state machine. All outputs are registered.
module mod_down_counter #(
  parameter int unsigned MAX_COUNT = 12,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RELOAD    = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             tc_o
);

  localparam int unsigned      PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT - 1);
  localparam logic [PsW-1:0]   PsLast = PsW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PsW-1:0]   ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             advance;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;
    advance = 1'b0;

    if (load_i) begin
      count_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
      ps_d    = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            if (count_q == '0) begin
              state_d = StDone;
              tc_d    = 1'b1;
            end else begin
              state_d = StRun;
              ps_d    = '0;
            end
          end
        end
        StRun: begin
          if (pause_i) begin
            state_d = StPaused;
          end else begin
            advance = 1'b1;
          end
        end
        StPaused: begin
          // Resume counts in the release cycle so each paused cycle costs exactly one cycle.
          if (!pause_i) begin
            state_d = StRun;
            advance = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (advance) begin
        if (ps_q == PsLast) begin
          ps_d = '0;
          if (count_q == '0) begin
            count_d = MaxVal;
          end else begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (RELOAD == 0) begin
                state_d = StDone;
              end
            end
          end
        end else begin
          ps_d = ps_q + PsW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o   = count_q;
  assign running_o = (state_q == StRun);
  assign tc_o      = tc_q;

endmodule

// File: doc/mod_down_counter.md
# mod_down_counter

Programmable modulo down-counter/timer, the countdown counterpart of the team's free-running modulo up-counter. The block loads a start value, decrements it at a prescaled rate, and flags the terminal count. It drives countdown displays through the hex-7seg decoder path and serves as a one-shot or periodic timer for control logic. Run, pause, abort and reload are handled by a small state machine.

## Interface
- MAX_COUNT, 12: modulus; the count range is 0..MAX_COUNT-1. Must be ≥ 2 and ≤ 2**WIDTH.
- WIDTH, 4: count width in bits.
- PRESCALE, 1: number of clk cycles per decrement while running. Must be ≥ 1.
- RELOAD, 0: 0 = one-shot (stop at 0); 1 = periodic (wrap 0 → MAX_COUNT-1).
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  capture load_val; highest-priority command.
- load_val  in  WIDTH  value to load.
- start  in  1  begin or resume counting from the current count.
- pause  in  1  level; freezes counting while high.
- count  out  WIDTH  current count, registered.
- running  out  1  high in the RUN state only.
- tc  out  1  terminal-count pulse, one clk wide, registered.

## Operation
- **Reset** (rst=0, asynchronous): state=IDLE, count=0, prescaler=0, tc=0, running=0.
- **States:** IDLE, RUN, PAUSED, DONE.
- **Command priority** in every state: load > start > pause.
- **load** (any state): count ← min(load_val, MAX_COUNT-1), prescaler ← 0, state → IDLE. An active run is aborted and tc is not asserted.
- **start** (IDLE or DONE, no load):
  - If count = 0 → DONE, tc=1 for one cycle.
  - Otherwise → RUN, prescaler ← 0.
  - start in RUN or PAUSED is ignored.
- **RUN:**
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler = PRESCALE-1).
  - On a tick, count ← count-1.
- **Reaching 0 in RUN** (tick with count = 1):
  - count ← 0 and tc ← 1.
  - RELOAD=0: state → DONE.
  - RELOAD=1: state stays RUN.
- **RELOAD=1 wrap:** the next tick with count = 0 sets count ← MAX_COUNT-1, with no tc on the wrap.
- **pause=1 in RUN** → PAUSED. count and prescaler are frozen.
- **pause=0 in PAUSED** → RUN. Counting resumes with the prescaler phase preserved.
- **Simultaneous pause and tick:** pause wins and no decrement occurs in that cycle.
- **DONE:** holds count=0 until load or start. A start from DONE with count=0 gives another immediate tc pulse.
- **Width rules:**
  - Decrement is modulo MAX_COUNT; count never leaves 0..MAX_COUNT-1.
  - Clamp compare is done at WIDTH bits.
  - The prescaler width is ceil(log2(PRESCALE)), with a minimum of 1.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- **start** sampled at edge k:
  - running=1 from edge k.
  - First decrement at edge k+PRESCALE.
  - From value V, count=0 and tc=1 after edge k+V·PRESCALE.
  - tc falls at the next edge.
- **One-shot:** running falls at the same edge at which count reaches 0.
- **Periodic:** wrap to MAX_COUNT-1 at edge k+(V+1)·PRESCALE. Period = MAX_COUNT·PRESCALE cycles, with one tc per period.
- **load** sampled at edge k: count valid after edge k, running=0 after edge k.
- **Pause latency:** pause seen at edge k freezes count from edge k. Each paused cycle adds exactly one cycle to the total run time.
- **Asynchronous reset mid-run:** outputs clear immediately and tc is never left high.

## Test plan
- **One-shot countdown** (PRESCALE=1, RELOAD=0): load 5, start at edge k → count 5,4,3,2,1,0 at edges k+1..k+5; tc=1 only after edge k+5; running=0 from edge k+5; count holds 0.
- **Clamp and prescale** (PRESCALE=3): load 15 → count=11; start → count steps every 3 cycles; tc after 33 cycles.
- **Periodic** (RELOAD=1): load 2, start → 1, 0 (tc), 11, 10, …, 0 (tc); 12 cycles between tc pulses; running stays 1.
- **Pause** (PRESCALE=1): load 6, start, pause for 4 cycles after count=4 → count holds 4 for 4 cycles; tc arrives 4 cycles later than without the pause.
- **Abort and priority:** during RUN at count=7, assert load=1 (load_val=3), start=1 and pause=1 together → IDLE, count=3, running=0, no tc.
- **Reset and zero start:** drop rst while count=9 in RUN → count=0, running=0, tc=0 immediately. After release, start with count=0 → DONE and a single tc pulse.
